// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants and state encoding for the data-side store buffer
//
// Purpose : widths of the single-cycle MIPS data path and the store-buffer
//           memory-side FSM encoding.
// Ports   : none (package).
package mips_pkg;

   localparam int MIPS_AW = 32;
   localparam int MIPS_DW = 32;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WR   = 2'd1,
      S_RD   = 2'd2
   } sb_state_t;

endpackage

// File: rtl/sb_fifo.sv
// rtl/sb_fifo.sv - posted-store FIFO with youngest-first associative load match
//
// Purpose : holds posted stores as {word tag, data}, exposes the head entry
//           for draining and searches all valid entries for a load address.
// Ports   : clk, rst (async, active low)
//           push/push_tag/push_data  enqueue at the rising edge
//           pop                      discard head at the rising edge
//           head_tag/head_data       oldest entry
//           count                    number of valid entries (0..DEPTH)
//           match_tag -> hit/hit_data  youngest matching entry
module sb_fifo
   import mips_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = MIPS_AW,
   parameter int DW    = MIPS_DW
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      push,
   input  logic [AW-3:0]             push_tag,
   input  logic [DW-1:0]             push_data,
   input  logic                      pop,
   output logic [AW-3:0]             head_tag,
   output logic [DW-1:0]             head_data,
   output logic [$clog2(DEPTH):0]    count,
   input  logic [AW-3:0]             match_tag,
   output logic                      hit,
   output logic [DW-1:0]             hit_data
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [AW-3:0] tag_q  [DEPTH];
   logic [DW-1:0] data_q [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] idx;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Payload needs no reset: only entries below count are ever observed.
   always_ff @(posedge clk) begin
      if (push) begin
         tag_q[wr_ptr]  <= push_tag;
         data_q[wr_ptr] <= push_data;
      end
   end

   assign head_tag  = tag_q[rd_ptr];
   assign head_data = data_q[rd_ptr];

   // Walk entries oldest to youngest; a later match overrides an earlier one,
   // so the youngest store to the word wins.
   always_comb begin
      hit      = 1'b0;
      hit_data = '0;
      idx      = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = rd_ptr + PW'(i);
         if ((CW'(i) < count) && (tag_q[idx] == match_tag)) begin
            hit      = 1'b1;
            hit_data = data_q[idx];
         end
      end
   end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - posted-store buffer between the MIPS core and a handshaked data SRAM
//
// Purpose : posts core stores into sb_fifo and drains them in the background,
//           forwards loads from buffered stores, and stalls the core on a
//           full buffer or a load miss until the SRAM read returns.
// Ports   : clk, rst (async, active low)
//           core : memwrite, memread, addr, wdata -> rdata, stall, sb_empty
//           sram : mem_req, mem_we, mem_addr, mem_wdata <- mem_ack, mem_rdata
module store_buffer
   import mips_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = MIPS_AW,
   parameter int DW    = MIPS_DW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          memwrite,
   input  logic          memread,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata,
   output logic          stall,
   output logic          sb_empty,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic          mem_ack,
   input  logic [DW-1:0] mem_rdata
);

   localparam int CW = $clog2(DEPTH) + 1;

   sb_state_t     state;
   sb_state_t     state_n;
   logic [CW-1:0] count;
   logic [AW-3:0] head_tag;
   logic [DW-1:0] head_data;
   logic          hit;
   logic [DW-1:0] hit_data;
   logic [DW-1:0] rdata_q;
   logic          rd_valid;
   logic          full;
   logic          load;
   logic          miss;
   logic          push;
   logic          pop;
   logic          ack;
   logic          issue_wr;
   logic          issue_rd;
   logic          unused_byte_addr;

   // Byte offset is irrelevant for word-only accesses.
   assign unused_byte_addr = ^addr[1:0];

   sb_fifo #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .DW    (DW)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_tag  (addr[AW-1:2]),
      .push_data (wdata),
      .pop       (pop),
      .head_tag  (head_tag),
      .head_data (head_data),
      .count     (count),
      .match_tag (addr[AW-1:2]),
      .hit       (hit),
      .hit_data  (hit_data)
   );

   // A store wins over a simultaneous load request.
   assign load = memread & ~memwrite;
   assign full = (count == CW'(DEPTH));
   assign push = memwrite & ~full;
   assign miss = load & ~hit & ~rd_valid;
   assign ack  = mem_ack & mem_req;

   // Gating with rst keeps stall low while the core is held in reset.
   assign stall    = rst & ((memwrite & full) | miss);
   assign sb_empty = (count == '0) && (state == S_IDLE);
   assign rdata    = (load & hit) ? hit_data : rdata_q;

   // Draining always beats a read; a read only goes out once every older
   // store, including the in-flight one, has completed.
   always_comb begin
      state_n  = state;
      pop      = 1'b0;
      issue_wr = 1'b0;
      issue_rd = 1'b0;
      case (state)
         S_IDLE: begin
            if (count != '0) begin
               state_n  = S_WR;
               pop      = 1'b1;
               issue_wr = 1'b1;
            end else if (miss) begin
               state_n  = S_RD;
               issue_rd = 1'b1;
            end
         end
         S_WR:    if (ack) state_n = S_IDLE;
         S_RD:    if (ack) state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rd_valid  <= 1'b0;
         rdata_q   <= '0;
      end else begin
         state <= state_n;

         if (issue_wr) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= {head_tag, 2'b00};
            mem_wdata <= head_data;
         end else if (issue_rd) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= {addr[AW-1:2], 2'b00};
         end else if (ack) begin
            mem_req   <= 1'b0;
         end

         // rd_valid lives for exactly the one cycle in which the core
         // consumes the read data. Forwarded data is also latched so rdata
         // keeps showing the last load result once memread drops.
         if ((state == S_RD) && ack) begin
            rd_valid <= 1'b1;
            rdata_q  <= mem_rdata;
         end else begin
            rd_valid <= 1'b0;
            if (load & hit) rdata_q <= hit_data;
         end
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - scoreboard testbench for store_buffer
module tb_store_buffer;

   typedef struct {
      logic        we;
      logic [31:0] a;
      logic [31:0] d;
   } txn_t;

   logic        clk;
   logic        rst;
   logic        memwrite;
   logic        memread;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        stall;
   logic        sb_empty;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   txn_t        exp_txn[$];
   logic [31:0] exp_load[$];
   int          passed = 0;
   int          total  = 0;
   int          ack_delay = 0;
   bit          ack_block = 0;
   int          wait_cnt  = 0;

   store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .memwrite  (memwrite),
      .memread   (memread),
      .addr      (addr),
      .wdata     (wdata),
      .rdata     (rdata),
      .stall     (stall),
      .sb_empty  (sb_empty),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
   endtask

   // SRAM model: acks ack_delay cycles after seeing mem_req, one-cycle pulse.
   initial begin
      mem_ack = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst) begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
         end else if (mem_ack) begin
            mem_ack = 1'b0;
         end else if (mem_req && !ack_block) begin
            if (wait_cnt >= ack_delay) begin
               mem_ack  = 1'b1;
               wait_cnt = 0;
            end else begin
               wait_cnt++;
            end
         end
      end
   end

   // Memory-side monitor: every new request is matched against the scoreboard
   // and must still carry the same fields on its ack cycle.
   initial begin
      logic prev;
      logic have_e;
      txn_t e;
      prev   = 1'b0;
      have_e = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            prev   = 1'b0;
            have_e = 1'b0;
         end else begin
            if (mem_req && !prev) begin
               if (exp_txn.size() == 0) begin
                  total++;
                  have_e = 1'b0;
                  $display("FAIL unexpected_req: actual we=%0d addr=0x%08h required no request", mem_we, mem_addr);
               end else begin
                  e = exp_txn.pop_front();
                  have_e = 1'b1;
                  chk("txn_we", 32'(mem_we), 32'(e.we));
                  chk("txn_addr", mem_addr, e.a);
                  if (e.we) chk("txn_wdata", mem_wdata, e.d);
               end
            end
            if (mem_req && mem_ack && have_e) begin
               chk("txn_hold_we", 32'(mem_we), 32'(e.we));
               chk("txn_hold_addr", mem_addr, e.a);
               if (e.we) chk("txn_hold_wdata", mem_wdata, e.d);
            end
            prev = mem_req;
         end
      end
   end

   // Core-side monitor: a load completes in the cycle it is not stalled.
   initial begin
      forever begin
         @(negedge clk);
         if (rst && memread && !memwrite && !stall) begin
            if (exp_load.size() == 0) begin
               total++;
               $display("FAIL unexpected_load: actual rdata=0x%08h required no load", rdata);
            end else begin
               chk("load_rdata", rdata, exp_load.pop_front());
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic exp_rd(input logic [31:0] a);
      txn_t t;
      t.we = 1'b0;
      t.a  = {a[31:2], 2'b00};
      t.d  = '0;
      exp_txn.push_back(t);
   endtask

   task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic rd_too,
                           input logic push_exp, output int stalls);
      txn_t t;
      t.we = 1'b1;
      t.a  = {a[31:2], 2'b00};
      t.d  = d;
      if (push_exp) exp_txn.push_back(t);
      memwrite = 1'b1;
      memread  = rd_too;
      addr     = a;
      wdata    = d;
      stalls   = 0;
      @(negedge clk);
      while (stall && stalls < 200) begin
         stalls++;
         @(negedge clk);
      end
      if (stalls >= 200) begin
         total++;
         $display("FAIL store_timeout: actual stall=1 required stall=0 within 200 cycles");
      end
      @(posedge clk);
      #1;
      memwrite = 1'b0;
      memread  = 1'b0;
   endtask

   task automatic do_load(input logic [31:0] a, input logic [31:0] exp_data, output int stalls);
      exp_load.push_back(exp_data);
      memread  = 1'b1;
      memwrite = 1'b0;
      addr     = a;
      stalls   = 0;
      @(negedge clk);
      while (stall && stalls < 200) begin
         stalls++;
         @(negedge clk);
      end
      if (stalls >= 200) begin
         total++;
         $display("FAIL load_timeout: actual stall=1 required stall=0 within 200 cycles");
      end
      @(posedge clk);
      #1;
      memread = 1'b0;
   endtask

   task automatic wait_empty(input string name);
      int n;
      n = 0;
      while (!sb_empty && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk(name, 32'(sb_empty), 32'd1);
      tick(1);
   endtask

   initial begin
      int s;
      int s6;
      int hi;

      // Reset state, with a load request present to prove stall is held low.
      rst       = 1'b0;
      memwrite  = 1'b0;
      memread   = 1'b1;
      addr      = 32'h300;
      wdata     = '0;
      mem_rdata = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_stall", 32'(stall), 32'd0);
      chk("reset_sb_empty", 32'(sb_empty), 32'd1);
      chk("reset_mem_req", 32'(mem_req), 32'd0);
      chk("reset_mem_we", 32'(mem_we), 32'd0);
      chk("reset_mem_addr", mem_addr, 32'd0);
      chk("reset_mem_wdata", mem_wdata, 32'd0);
      chk("reset_rdata", rdata, 32'd0);
      memread = 1'b0;
      rst     = 1'b1;
      tick(1);

      // Reset mid-write: the in-flight request and buffered store vanish.
      ack_block = 1'b1;
      do_store(32'h500, 32'h55555555, 1'b0, 1'b0, s);
      do_store(32'h504, 32'h66666666, 1'b0, 1'b0, s);
      chk("rst_pre_req", 32'(mem_req), 32'd1);
      rst = 1'b0;
      #1;
      chk("rst_req_drop", 32'(mem_req), 32'd0);
      chk("rst_sb_empty", 32'(sb_empty), 32'd1);
      ack_block = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b1;
      hi  = 0;
      repeat (10) begin
         @(negedge clk);
         if (mem_req) hi++;
      end
      chk("rst_no_req", 32'(hi), 32'd0);
      tick(1);

      // Posted store drain with a 3-cycle ack delay.
      ack_delay = 3;
      do_store(32'h100, 32'h11111111, 1'b0, 1'b1, s);
      chk("drain_stall", 32'(s), 32'd0);
      chk("drain_not_empty", 32'(sb_empty), 32'd0);
      wait_empty("drain_empty");

      // Full stall: one store in flight plus four buffered, the sixth waits.
      ack_delay = 0;
      ack_block = 1'b1;
      for (int i = 0; i < 5; i++) begin
         do_store(32'h10 + 32'(i) * 4, 32'hF0 + 32'(i), 1'b0, 1'b1, s);
         chk("full_nostall", 32'(s), 32'd0);
      end
      fork
         do_store(32'h24, 32'hF5, 1'b0, 1'b1, s6);
         begin
            tick(4);
            #2;
            ack_block = 1'b0;
         end
      join
      chk("full_stall", 32'(s6 > 0), 32'd1);
      wait_empty("full_drain");

      // Forwarding: youngest of two stores to the same word wins.
      ack_block = 1'b1;
      do_store(32'h60, 32'h00001234, 1'b0, 1'b1, s);
      do_store(32'h40, 32'h0000AAAA, 1'b0, 1'b1, s);
      do_store(32'h44, 32'h0000CCCC, 1'b0, 1'b1, s);
      do_store(32'h40, 32'h0000BBBB, 1'b0, 1'b1, s);
      do_load(32'h42, 32'h0000BBBB, s);
      chk("fwd_young_stall", 32'(s), 32'd0);
      chk("fwd_rdata_hold", rdata, 32'h0000BBBB);
      do_load(32'h47, 32'h0000CCCC, s);
      chk("fwd_other_stall", 32'(s), 32'd0);
      ack_block = 1'b0;
      wait_empty("fwd_drain");

      // Load miss waits behind an older store, then returns SRAM data.
      ack_delay = 1;
      mem_rdata = 32'hDEADBEEF;
      do_store(32'h80, 32'h80808080, 1'b0, 1'b1, s);
      exp_rd(32'h200);
      do_load(32'h200, 32'hDEADBEEF, s);
      chk("miss_stalled", 32'(s >= 3), 32'd1);
      tick(1);
      mem_rdata = 32'h5A5A5A5A;
      exp_rd(32'h207);
      do_load(32'h207, 32'h5A5A5A5A, s);
      chk("miss_min_latency", 32'(s), 32'd3);
      chk("miss_rdata_hold", rdata, 32'h5A5A5A5A);
      mem_rdata = '0;

      // Simultaneous memwrite/memread behaves as a plain store.
      ack_delay = 0;
      do_store(32'h300, 32'h33333333, 1'b1, 1'b1, s);
      chk("simul_stall", 32'(s), 32'd0);
      wait_empty("simul_drain");
      tick(5);

      chk("txn_queue_empty", 32'(exp_txn.size()), 32'd0);
      chk("load_queue_empty", 32'(exp_load.size()), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
